sr_flip_flop_bank: RTL and testbench

//   Parametrised, clocked successor of the single gated SR latch: WIDTH independent

---
 rtl/ff_bank_pkg.sv | 51 +++++
 rtl/ff_cell.sv | 37 +++
 rtl/sr_flip_flop_bank.sv | 78 +++++++
 tb/tb_sr_flip_flop_bank.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// Shared mode/policy codes and the per-channel next-state function for the
// flip-flop bank.
package ff_bank_pkg;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam int unsigned POL_HOLD   = 0;
  localparam int unsigned POL_SET    = 1;
  localparam int unsigned POL_RESET  = 2;
  localparam int unsigned POL_TOGGLE = 3;

  // The reset input is a don't-care in D and T modes.
  function automatic logic ff_next(input logic [1:0] mode, input logic s,
                                   input logic r, input logic q,
                                   input int unsigned policy);
    logic nq;
    nq = q;
    case (mode)
      MODE_SR: begin
        case ({s, r})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11: begin
            case (policy)
              POL_SET:    nq = 1'b1;
              POL_RESET:  nq = 1'b0;
              POL_TOGGLE: nq = ~q;
              default:    nq = q;
            endcase
          end
          default: nq = q;
        endcase
      end
      MODE_JK: begin
        case ({s, r})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11:   nq = ~q;
          default: nq = q;
        endcase
      end
      MODE_D:  nq = s;
      default: nq = s ? ~q : q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One flip-flop channel: next-state logic, Q register with asynchronous clear,
// and the forbidden-input indication for the bank-level flags.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic        RESET_BIT   = 1'b0,
  parameter int unsigned SR11_POLICY = POL_HOLD
) (
  input  logic       cp,
  input  logic       clr,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic       s,
  input  logic       r,
  output logic       q,
  output logic       forbidden
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d       = ff_next(mode, s, r, q_q, SR11_POLICY);
    forbidden = enable & (mode == MODE_SR) & s & r;
  end

  always_ff @(posedge cp or posedge clr) begin
    if (clr) begin
      q_q <= RESET_BIT;
    end else if (enable) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sr_flip_flop_bank.sv
// WIDTH-channel SR/JK/D/T flip-flop bank with sticky per-channel forbidden-input
// flags and a saturating count of cycles containing a forbidden input.
module sr_flip_flop_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned       WIDTH       = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL   = '0,
  parameter int unsigned       SR11_POLICY = POL_HOLD,
  parameter int unsigned       CNT_W       = 8
) (
  input  logic             cp,
  input  logic             clr,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] reset,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] notout,
  output logic [WIDTH-1:0] illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] forb_vec;
  logic [WIDTH-1:0] illegal_q;
  logic [WIDTH-1:0] illegal_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             any_forb;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    ff_cell #(
      .RESET_BIT   (RESET_VAL[gi]),
      .SR11_POLICY (SR11_POLICY)
    ) u_cell (
      .cp        (cp),
      .clr       (clr),
      .enable    (enable),
      .mode      (mode),
      .s         (set[gi]),
      .r         (reset[gi]),
      .q         (q_vec[gi]),
      .forbidden (forb_vec[gi])
    );
  end

  // A forbidden event in the clearing cycle survives the clear.
  always_comb begin
    any_forb  = |forb_vec;
    illegal_d = illegal_q | forb_vec;
    cnt_d     = cnt_q;
    if (flag_clr) begin
      illegal_d = forb_vec;
      cnt_d     = any_forb ? CNT_W'(1) : '0;
    end else if (any_forb && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge cp or posedge clr) begin
    if (clr) begin
      illegal_q <= '0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out         = q_vec;
  assign notout      = ~q_vec;
  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_sr_flip_flop_bank.sv
// Directed bench: one hold-policy bank (8-bit counter) and one toggle-policy
// bank (2-bit counter) driven by the same stimulus.
module tb_sr_flip_flop_bank;

  logic       cp = 1'b0;
  logic       clr = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] set = 4'b0000;
  logic [3:0] reset = 4'b0000;
  logic       flag_clr = 1'b0;

  logic [3:0] a_out, a_notout, a_illegal;
  logic [7:0] a_cnt;
  logic [3:0] b_out, b_notout, b_illegal;
  logic [1:0] b_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 cp = ~cp;

  sr_flip_flop_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .SR11_POLICY(0), .CNT_W(8)) dut_a (
    .cp(cp), .clr(clr), .enable(enable), .mode(mode), .set(set), .reset(reset),
    .flag_clr(flag_clr), .out(a_out), .notout(a_notout), .illegal(a_illegal),
    .illegal_cnt(a_cnt)
  );

  sr_flip_flop_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .SR11_POLICY(3), .CNT_W(2)) dut_b (
    .cp(cp), .clr(clr), .enable(enable), .mode(mode), .set(set), .reset(reset),
    .flag_clr(flag_clr), .out(b_out), .notout(b_notout), .illegal(b_illegal),
    .illegal_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] m, input logic [3:0] s,
                       input logic [3:0] r, input logic fc);
    enable   = en;
    mode     = m;
    set      = s;
    reset    = r;
    flag_clr = fc;
  endtask

  initial begin
    logic [3:0] jk_exp [4];
    jk_exp[0] = 4'b1111; jk_exp[1] = 4'b0000; jk_exp[2] = 4'b1111; jk_exp[3] = 4'b0000;

    #12;
    clr = 1'b0;
    check("por_out", a_out, 4'b1010);
    check("por_cnt", a_cnt, 8'd0);

    // Move away from reset value, then pulse clr mid-cycle.
    drive(1, 2'b10, 4'b0101, 4'b0000, 0);
    tick();
    check("d_load", a_out, 4'b0101);
    #2 clr = 1'b1;
    #1;
    check("clr_out", a_out, 4'b1010);
    check("clr_notout", a_notout, 4'b0101);
    check("clr_cnt", a_cnt, 8'd0);
    check("clr_illegal", a_illegal, 4'b0000);
    clr = 1'b0;

    // SR truth table on channel 0.
    drive(1, 2'b00, 4'b0000, 4'b0000, 0); tick();
    check("sr_00_hold", a_out, 4'b1010);
    drive(1, 2'b00, 4'b0000, 4'b0001, 0); tick();
    check("sr_01_reset", a_out, 4'b1010);
    drive(1, 2'b00, 4'b0001, 4'b0000, 0); tick();
    check("sr_10_set", a_out, 4'b1011);
    check("sr_10_notout", a_notout, 4'b0100);
    drive(1, 2'b00, 4'b0000, 4'b0001, 0); tick();
    check("sr_01_reset2", a_out, 4'b1010);
    check("sr_illegal_0", a_illegal, 4'b0000);

    // Forbidden S=R=1 on channels 1 and 2 for three cycles.
    drive(1, 2'b00, 4'b0110, 4'b0110, 0);
    repeat (3) tick();
    check("sr11_hold_out", a_out, 4'b1010);
    check("sr11_illegal", a_illegal, 4'b0110);
    check("sr11_cnt", a_cnt, 8'd3);
    check("sr11_tog_out", b_out, 4'b1100);
    check("sr11_tog_cnt", b_cnt, 2'd3);

    // Enable low: nothing moves regardless of inputs.
    for (int i = 0; i < 10; i++) begin
      drive(0, i[1:0], i[3:0] ^ 4'b1111, i[3:0] | 4'b0110, 0);
      tick();
      check($sformatf("gate_out_%0d", i), a_out, 4'b1010);
      check($sformatf("gate_cnt_%0d", i), a_cnt, 8'd3);
    end
    check("gate_illegal", a_illegal, 4'b0110);

    // JK toggle from 0, then T mode.
    drive(1, 2'b10, 4'b0000, 4'b0000, 0); tick();
    check("d_zero", a_out, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b01, 4'b1111, 4'b1111, 0); tick();
      check($sformatf("jk_tog_%0d", i), a_out, jk_exp[i]);
    end
    check("jk_no_flag", a_cnt, 8'd3);
    drive(1, 2'b11, 4'b1111, 4'b0000, 0); tick();
    check("t_all_1", a_out, 4'b1111);
    tick();
    check("t_all_2", a_out, 4'b0000);
    drive(1, 2'b11, 4'b0101, 4'b1111, 0); tick();
    check("t_part", a_out, 4'b0101);
    check("t_notout", a_notout, 4'b1010);

    // Saturation and flag clearing.
    #2 clr = 1'b1;
    #1 clr = 1'b0;
    drive(1, 2'b00, 4'b0011, 4'b0011, 0);
    repeat (5) tick();
    check("sat_cnt_b", b_cnt, 2'd3);
    check("sat_cnt_a", a_cnt, 8'd5);
    check("sat_illegal_b", b_illegal, 4'b0011);
    drive(1, 2'b00, 4'b0000, 4'b0000, 1); tick();
    check("fclr_cnt_b", b_cnt, 2'd0);
    check("fclr_illegal_b", b_illegal, 4'b0000);
    check("fclr_cnt_a", a_cnt, 8'd0);
    check("fclr_out_a", a_out, 4'b1010);
    drive(1, 2'b00, 4'b0001, 4'b0001, 0); tick();
    check("pre_illegal_b", b_illegal, 4'b0001);
    drive(1, 2'b00, 4'b1100, 4'b1000, 1); tick();
    check("win_illegal_b", b_illegal, 4'b1000);
    check("win_cnt_b", b_cnt, 2'd1);
    check("win_cnt_a", a_cnt, 8'd1);
    check("win_out_a", a_out, 4'b1110);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
